// File: rtl/modn_wrap_tracker.sv
// ---------------------------------------------------------------------------
// modn_wrap_tracker
//
// Watches the count bus of an upstream synchronous mod-N counter and checks
// that it advances 0,1,...,N-1,0,... one step per clock. Each legal N-1 -> 0
// rollover produces a one-cycle wrap_tick that advances a cascaded mod-M
// digit. Sequence errors are flagged (sticky), counted (saturating) and
// recovered from by resynchronising on the next zero.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   cnt_in     in   [MSB-1:0] count value from the mod-N counter
//   clr_err    in   clears seq_err / err_count (a same-cycle error wins)
//   wrap_tick  out  one-cycle pulse per legal N-1 -> 0 rollover
//   digit      out  [TMSB-1:0] mod-M count of wrap ticks
//   digit_wrap out  one-cycle pulse when digit rolls M-1 -> 0
//   seq_err    out  sticky sequence-error flag
//   err_count  out  [EW-1:0] saturating count of sequence errors
//   state      out  [1:0] 00 SYNC, 01 TRACK, 10 FAULT
// All outputs are registered: a response to cnt_in sampled at edge k is
// visible right after edge k.
// ---------------------------------------------------------------------------
module modn_wrap_tracker #(
    parameter int N    = 10,
    parameter int MSB  = 4,
    parameter int M    = 6,
    parameter int TMSB = 3,
    parameter int EW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [MSB-1:0]  cnt_in,
    input  logic            clr_err,
    output logic            wrap_tick,
    output logic [TMSB-1:0] digit,
    output logic            digit_wrap,
    output logic            seq_err,
    output logic [EW-1:0]   err_count,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    // Constants sized to their operands so compares never truncate.
    localparam logic [MSB-1:0]  CNT_MAX   = MSB'(N - 1);
    localparam logic [MSB:0]    CNT_LIMIT = (MSB + 1)'(N);
    localparam logic [TMSB-1:0] DIGIT_MAX = TMSB'(M - 1);
    localparam logic [EW-1:0]   ERR_MAX   = '1;

    state_t          state_q, state_d;
    logic [MSB-1:0]  prev_q, prev_d;
    logic            wrap_tick_q, wrap_tick_d;
    logic [TMSB-1:0] digit_q, digit_d;
    logic            digit_wrap_q, digit_wrap_d;
    logic            seq_err_q, seq_err_d;
    logic [EW-1:0]   err_count_q, err_count_d;

    logic [MSB:0]    expected;
    logic            cnt_legal;
    logic            cnt_match;
    logic            err_now;

    // Next expected value, computed one bit wider than the bus so prev+1
    // cannot wrap around to a small legal value.
    always_comb begin
        expected  = (prev_q == CNT_MAX) ? '0 : ({1'b0, prev_q} + (MSB + 1)'(1));
        // Out-of-range values never match, even if prev itself was illegal.
        cnt_legal = ({1'b0, cnt_in} < CNT_LIMIT);
        cnt_match = cnt_legal && ({1'b0, cnt_in} == expected);
    end

    always_comb begin
        state_d      = state_q;
        prev_d       = cnt_in;
        wrap_tick_d  = 1'b0;
        digit_d      = digit_q;
        digit_wrap_d = 1'b0;
        seq_err_d    = seq_err_q;
        err_count_d  = err_count_q;
        err_now      = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (cnt_in == '0) begin
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (cnt_match) begin
                    // A match with prev at the top can only be the rollover.
                    if (prev_q == CNT_MAX) begin
                        wrap_tick_d = 1'b1;
                        if (digit_q == DIGIT_MAX) begin
                            digit_d      = '0;
                            digit_wrap_d = 1'b1;
                        end else begin
                            digit_d = digit_q + TMSB'(1);
                        end
                    end
                end else begin
                    state_d = ST_FAULT;
                    err_now = 1'b1;
                end
            end
            ST_FAULT: begin
                // Only a zero resynchronises; other values are not recounted.
                if (cnt_in == '0) begin
                    state_d = ST_TRACK;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase

        // A new error takes priority over a simultaneous clear.
        if (err_now) begin
            seq_err_d = 1'b1;
            if (clr_err) begin
                err_count_d = EW'(1);
            end else if (err_count_q != ERR_MAX) begin
                err_count_d = err_count_q + EW'(1);
            end
        end else if (clr_err) begin
            seq_err_d   = 1'b0;
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SYNC;
            prev_q       <= '0;
            wrap_tick_q  <= 1'b0;
            digit_q      <= '0;
            digit_wrap_q <= 1'b0;
            seq_err_q    <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            wrap_tick_q  <= wrap_tick_d;
            digit_q      <= digit_d;
            digit_wrap_q <= digit_wrap_d;
            seq_err_q    <= seq_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign wrap_tick  = wrap_tick_q;
    assign digit      = digit_q;
    assign digit_wrap = digit_wrap_q;
    assign seq_err    = seq_err_q;
    assign err_count  = err_count_q;
    assign state      = state_q;

endmodule
